// File: rtl/instr_fetch_unit.sv
// Prefetching instruction fetch unit: sequential word fetch over req/ack, small {pc, word} FIFO to decode.
// Optional FETCH_ALIGN_CHK_EN: flag misaligned redirect targets and stall fetching until an aligned redirect.
module instr_fetch_unit #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        misaligned
);
    localparam int            CW   = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

    state_t                  r_state, w_state_nxt;
    logic [31:0]             r_fpc, w_fpc_nxt;
    logic [31:0]             r_mem_addr, w_addr_nxt;
    logic [CW-1:0]           r_count, w_count_nxt, w_base;
    logic [DEPTH-1:0][31:0]  r_word, r_pc, w_word_nxt, w_pc_nxt;
    logic                    r_mem_req, r_valid, r_mis, w_mis_nxt;
    logic                    w_pop, w_push, w_rpc_mis;
    logic [31:0]             w_rpc;

`ifdef FETCH_ALIGN_CHK_EN
    assign w_rpc     = redirect_pc;
    assign w_rpc_mis = |redirect_pc[1:0];
`else
    assign w_rpc     = redirect_pc & ~32'h3;
    assign w_rpc_mis = 1'b0;
`endif

    // Valid mirrors count != 0, so a pop on an empty FIFO can never happen.
    assign w_pop  = r_valid && instr_ready;
    assign w_base = r_count - CW'(w_pop);

    always_comb begin
        w_state_nxt = r_state;
        w_fpc_nxt   = r_fpc;
        w_addr_nxt  = r_mem_addr;
        w_mis_nxt   = r_mis;
        w_count_nxt = w_base;
        w_push      = 1'b0;
        if (redirect) begin
            w_count_nxt = '0;
            w_fpc_nxt   = w_rpc;
            w_mis_nxt   = w_rpc_mis;
            // An unacked request must still complete; its data is dropped later.
            if ((r_state == REQ || r_state == DROP) && !mem_ack) begin
                w_state_nxt = DROP;
            end else if (w_rpc_mis) begin
                w_state_nxt = IDLE;
            end else begin
                w_state_nxt = REQ;
                w_addr_nxt  = w_rpc;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_base < FULL && !r_mis) begin
                        w_state_nxt = REQ;
                        w_addr_nxt  = r_fpc;
                    end
                end
                REQ: begin
                    if (mem_ack) begin
                        w_push      = 1'b1;
                        w_fpc_nxt   = r_fpc + 32'd4;
                        w_count_nxt = w_base + CW'(1);
                        if (w_base + CW'(1) < FULL) begin
                            w_addr_nxt = r_fpc + 32'd4;
                        end else begin
                            w_state_nxt = IDLE;
                        end
                    end
                end
                DROP: begin
                    if (mem_ack) begin
                        if (r_mis) begin
                            w_state_nxt = IDLE;
                        end else begin
                            w_state_nxt = REQ;
                            w_addr_nxt  = r_fpc;
                        end
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Shift FIFO keeps the head in slot 0 so instr/instr_pc come straight from flops.
    always_comb begin
        w_word_nxt = r_word;
        w_pc_nxt   = r_pc;
        if (w_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                w_word_nxt[i] = r_word[i+1];
                w_pc_nxt[i]   = r_pc[i+1];
            end
        end
        if (w_push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) == w_base) begin
                    w_word_nxt[i] = mem_rdata;
                    w_pc_nxt[i]   = r_fpc;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_fpc      <= RESET_PC;
            r_mem_addr <= RESET_PC;
            r_mem_req  <= 1'b0;
            r_count    <= '0;
            r_valid    <= 1'b0;
            r_mis      <= 1'b0;
            r_word     <= '0;
            r_pc       <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fpc      <= w_fpc_nxt;
            r_mem_addr <= w_addr_nxt;
            r_mem_req  <= (w_state_nxt != IDLE);
            r_count    <= w_count_nxt;
            r_valid    <= (w_count_nxt != '0);
            r_mis      <= w_mis_nxt;
            r_word     <= w_word_nxt;
            r_pc       <= w_pc_nxt;
        end
    end

    assign mem_req     = r_mem_req;
    assign mem_addr    = r_mem_addr;
    assign instr       = r_word[0];
    assign instr_pc    = r_pc[0];
    assign instr_valid = r_valid;
    assign misaligned  = r_mis;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed + randomized bench for instr_fetch_unit; a delivery-order model tracks the expected PC stream.
module tb_instr_fetch_unit;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst, redirect, mem_req, mem_ack, instr_valid, instr_ready, misaligned;
    logic [31:0] redirect_pc, mem_addr, mem_rdata, instr, instr_pc;

    int checks = 0;
    int errors = 0;
    int mem_mode = 0, mem_wait = 0, wcnt = 0;
    int n_deliv = 0;

    logic [31:0] exp_pc = 32'h0;
    logic        p_req = 1'b0, p_stall = 1'b0, p_redir = 1'b0;
    logic [31:0] p_addr = 32'h0, p_instr = 32'h0, p_pc = 32'h0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .misaligned(misaligned)
    );

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return a + 32'h100;
    endfunction

    function automatic logic [31:0] target(input logic [31:0] a);
`ifdef FETCH_ALIGN_CHK_EN
        return a;
`else
        return {a[31:2], 2'b00};
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: inputs change 1 time unit after the edge; memory answers the registered request.
    task automatic cyc();
        @(posedge clk);
        #1;
        redirect = 1'b0;
        if (mem_req && !rst) begin
            case (mem_mode)
                0:       mem_ack = 1'b1;
                1:       mem_ack = (wcnt >= mem_wait);
                2:       mem_ack = ($urandom_range(0, 2) == 0);
                default: mem_ack = 1'b0;
            endcase
            wcnt = mem_ack ? 0 : wcnt + 1;
        end else begin
            mem_ack = 1'b0;
            wcnt    = 0;
        end
        mem_rdata = mem_ack ? memfn(mem_addr) : $urandom;
    endtask

    task automatic wait_valid(input string tag);
        int t = 0;
        while (!instr_valid && t < 30) begin
            cyc();
            t++;
        end
        chk(tag, 32'(instr_valid), 32'd1);
    endtask

    // Reference: delivered instructions form a +4 PC stream restarting at every redirect target,
    // each carrying the memory word of its own PC; plus handshake/stall hold properties.
    always @(negedge clk) begin
        if (rst) begin
            p_req   <= 1'b0;
            p_stall <= 1'b0;
            p_redir <= 1'b0;
            exp_pc  <= 32'h0;
        end else begin
            if (p_req) begin
                chk("req_hold_req", 32'(mem_req), 32'd1);
                chk("req_hold_addr", mem_addr, p_addr);
            end
            if (p_stall) begin
                chk("stall_valid", 32'(instr_valid), 32'd1);
                chk("stall_instr", instr, p_instr);
                chk("stall_pc", instr_pc, p_pc);
            end
            if (p_redir) chk("flush_valid", 32'(instr_valid), 32'd0);
            if (redirect) begin
                exp_pc <= target(redirect_pc);
            end else if (instr_valid && instr_ready) begin
                chk("deliv_pc", instr_pc, exp_pc);
                chk("deliv_instr", instr, memfn(exp_pc));
                exp_pc  <= exp_pc + 32'd4;
                n_deliv <= n_deliv + 1;
            end
            p_req   <= mem_req && !mem_ack;
            p_addr  <= mem_addr;
            p_stall <= instr_valid && !instr_ready && !redirect;
            p_instr <= instr;
            p_pc    <= instr_pc;
            p_redir <= redirect;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int pushes;
        int nd0;
        int t;
        rst = 1'b1; redirect = 1'b0; redirect_pc = 32'h0;
        instr_ready = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
        repeat (2) cyc();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);
        chk("rst_misaligned", 32'(misaligned), 32'd0);

        // Streaming: ack every cycle, core always ready.
        mem_mode = 0; instr_ready = 1'b1; rst = 1'b0;
        chk("pre_edge_req", 32'(mem_req), 32'd0);
        cyc();
        chk("first_req", 32'(mem_req), 32'd1);
        chk("first_addr", mem_addr, 32'h0);
        for (int k = 1; k <= 5; k++) begin
            cyc();
            chk("seq_addr", mem_addr, 32'(4 * k));
            chk("seq_valid", 32'(instr_valid), 32'd1);
            chk("seq_pc", instr_pc, 32'(4 * (k - 1)));
            chk("seq_instr", instr, 32'(4 * (k - 1)) + 32'h100);
        end

        // Core stalls: FIFO fills to DEPTH then requests stop.
        instr_ready = 1'b0; redirect = 1'b1; redirect_pc = 32'h1000;
        cyc();
        chk("redir_valid", 32'(instr_valid), 32'd0);
        chk("redir_addr", mem_addr, 32'h1000);
        pushes = 0;
        for (int k = 0; k < 10; k++) begin
            pushes += int'(mem_ack);
            cyc();
        end
        chk("stall_pushes", 32'(pushes), 32'(DEPTH));
        chk("stall_req_low", 32'(mem_req), 32'd0);
        chk("stall_head", instr, 32'h1100);
        chk("stall_head_pc", instr_pc, 32'h1000);
        instr_ready = 1'b1;
        cyc();
        chk("resume_req", 32'(mem_req), 32'd1);
        chk("resume_addr", mem_addr, 32'h1010);
        chk("resume_pc", instr_pc, 32'h1004);
        t = 0;
        while (exp_pc != 32'h1010 && t < 20) begin
            cyc();
            t++;
        end
        chk("drain_done", exp_pc, 32'h1010);

        // Mid-operation reset is asynchronous.
        rst = 1'b1;
        #1;
        chk("async_rst_req", 32'(mem_req), 32'd0);
        chk("async_rst_valid", 32'(instr_valid), 32'd0);
        chk("async_rst_addr", mem_addr, 32'h0);
        mem_mode = 1; mem_wait = 3;
        cyc(); cyc();
        rst = 1'b0;

        // Redirect while a slow request is outstanding.
        cyc();
        chk("slow_req", 32'(mem_req), 32'd1);
        chk("slow_addr", mem_addr, 32'h0);
        cyc();
        redirect = 1'b1; redirect_pc = 32'h200;
        cyc();
        chk("drop_req", 32'(mem_req), 32'd1);
        chk("drop_addr", mem_addr, 32'h0);
        cyc();
        chk("drop_ack_addr", mem_addr, 32'h0);
        cyc();
        chk("after_drop_addr", mem_addr, 32'h200);
        chk("after_drop_valid", 32'(instr_valid), 32'd0);
        wait_valid("drop_first_valid");
        chk("drop_first_pc", instr_pc, 32'h200);
        chk("drop_first_instr", instr, 32'h300);

        // Redirect coinciding with an ack while two entries are buffered.
        mem_mode = 0; instr_ready = 1'b0;
        rst = 1'b1; cyc(); cyc(); rst = 1'b0;
        cyc(); cyc(); cyc();
        chk("two_head_pc", instr_pc, 32'h0);
        redirect = 1'b1; redirect_pc = 32'h400;
        cyc();
        chk("ackredir_valid", 32'(instr_valid), 32'd0);
        chk("ackredir_addr", mem_addr, 32'h400);
        instr_ready = 1'b1;
        wait_valid("ackredir_first_valid");
        chk("ackredir_first_pc", instr_pc, 32'h400);

        // Address wrap at the top of the address space.
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        cyc();
        chk("wrap_a0", mem_addr, 32'hFFFF_FFF8);
        cyc();
        chk("wrap_a1", mem_addr, 32'hFFFF_FFFC);
        cyc();
        chk("wrap_a2", mem_addr, 32'h0000_0000);
        cyc();
        chk("wrap_pc", instr_pc, 32'h0000_0000);

        // Misaligned redirect target.
        redirect = 1'b1; redirect_pc = 32'h102;
        cyc();
`ifdef FETCH_ALIGN_CHK_EN
        chk("mis_flag", 32'(misaligned), 32'd1);
        chk("mis_req", 32'(mem_req), 32'd0);
        repeat (3) cyc();
        chk("mis_req_held", 32'(mem_req), 32'd0);
        chk("mis_flag_held", 32'(misaligned), 32'd1);
        chk("mis_valid", 32'(instr_valid), 32'd0);
        redirect = 1'b1; redirect_pc = 32'h104;
        cyc();
        chk("mis_clear", 32'(misaligned), 32'd0);
        chk("mis_resume_req", 32'(mem_req), 32'd1);
        chk("mis_resume_addr", mem_addr, 32'h104);
`else
        chk("mis_tied", 32'(misaligned), 32'd0);
        chk("mis_force_req", 32'(mem_req), 32'd1);
        chk("mis_force_addr", mem_addr, 32'h100);
`endif

        // Random ack, ready and redirect traffic against the stream model.
        mem_mode = 2;
        nd0 = n_deliv;
        for (int k = 0; k < 3000; k++) begin
            cyc();
            instr_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 40) == 0) begin
                redirect    = 1'b1;
                redirect_pc = $urandom;
`ifdef FETCH_ALIGN_CHK_EN
                redirect_pc[1:0] = 2'b00;
`endif
            end
        end
        chk("rand_progress", 32'(n_deliv - nd0 > 200), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
